knap_exhaustive_search: RTL and testbench

- Sequential brute-force driver for the combinational knapsack validity checker.
- Enumerates every item-selection vector, one per clock, on `candidate`.
- Samples the checker's `valid` result in the same cycle.
- Counts feasible selections and keeps the highest-value feasible one. Sits directly upstream of the checker and owns the solve handshake to the host/testbench.

---
 rtl/knap_exhaustive_search.sv | 111 +++++++++++
 tb/tb_knap_exhaustive_search.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/knap_exhaustive_search.sv
// rtl/knap_exhaustive_search.sv - brute-force knapsack scan driving the validity checker
module knap_exhaustive_search #(
  parameter int                     N_ITEMS = 5,
  parameter int                     VW      = 5,
  parameter logic [N_ITEMS*VW-1:0]  VALUES  = {5'd10, 5'd1, 5'd2, 5'd2, 5'd4}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [N_ITEMS-1:0] candidate,
  input  logic               valid_in,
  output logic               busy,
  output logic               done,
  output logic               best_found,
  output logic [N_ITEMS-1:0] best_sel,
  output logic [VW-1:0]      best_value,
  output logic [N_ITEMS:0]   valid_count
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t             state_q, state_d;
  logic [N_ITEMS-1:0] cand_q, cand_d;
  logic               found_q, found_d;
  logic [N_ITEMS-1:0] sel_q, sel_d;
  logic [VW-1:0]      value_q, value_d;
  logic [N_ITEMS:0]   count_q, count_d;
  logic [VW-1:0]      sel_value;

  // Value of the current candidate; wraps mod 2^VW exactly like the checker's sum.
  always_comb begin
    sel_value = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (cand_q[i]) sel_value = sel_value + VALUES[i*VW +: VW];
    end
  end

  // Next-state logic: walk every selection once, tallying feasible ones and tracking the best.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    found_d = found_q;
    sel_d   = sel_q;
    value_d = value_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        cand_d = '0;
        if (start) begin
          state_d = SCAN;
          found_d = 1'b0;
          sel_d   = '0;
          value_d = '0;
          count_d = '0;
        end
      end
      SCAN: begin
        if (valid_in) begin
          count_d = count_q + (N_ITEMS+1)'(1);
          // Strict compare keeps the lowest-index selection on ties.
          if (!found_q || (sel_value > value_q)) begin
            found_d = 1'b1;
            sel_d   = cand_q;
            value_d = sel_value;
          end
        end
        if (&cand_q) begin
          state_d = DONE;
          cand_d  = '0;
        end else begin
          cand_d = cand_q + N_ITEMS'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cand_d  = '0;
      end
    endcase
  end

  // State and result registers with synchronous reset; reset mid-scan discards everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cand_q  <= '0;
      found_q <= 1'b0;
      sel_q   <= '0;
      value_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      found_q <= found_d;
      sel_q   <= sel_d;
      value_q <= value_d;
      count_q <= count_d;
    end
  end

  assign candidate   = cand_q;
  assign busy        = (state_q == SCAN);
  assign done        = (state_q == DONE);
  assign best_found  = found_q;
  assign best_sel    = sel_q;
  assign best_value  = value_q;
  assign valid_count = count_q;

endmodule

// File: tb/tb_knap_exhaustive_search.sv
// tb/tb_knap_exhaustive_search.sv - self-checking bench for knap_exhaustive_search
module tb_knap_exhaustive_search;

  logic       clk;
  logic       rst;
  logic       start;
  logic [4:0] candidate;
  logic       valid_in;
  logic       busy;
  logic       done;
  logic       best_found;
  logic [4:0] best_sel;
  logic [4:0] best_value;
  logic [5:0] valid_count;

  logic [31:0] mask_v;
  int          pass_cnt;
  int          total_cnt;

  // Per-item values, item A first.
  int item_val [5] = '{4, 2, 2, 1, 10};

  typedef struct {
    logic [31:0] mask;
    int          count;
    int          found;
    int          sel;
    int          value;
    string       tag;
  } vec_t;

  vec_t vecs [5];

  knap_exhaustive_search dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .candidate   (candidate),
    .valid_in    (valid_in),
    .busy        (busy),
    .done        (done),
    .best_found  (best_found),
    .best_sel    (best_sel),
    .best_value  (best_value),
    .valid_count (valid_count)
  );

  // Checker stub: feasibility is a lookup in a 32-entry mask.
  assign valid_in = mask_v[candidate];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    total_cnt++;
    if (actual == expected) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, actual, expected);
  endtask

  // Reference: enumerate all selections, keep the first strictly-highest feasible one.
  task automatic model(input logic [31:0] m, output int cnt, output int fnd,
                       output int sel, output int val);
    cnt = 0; fnd = 0; sel = 0; val = 0;
    for (int s = 0; s < 32; s++) begin
      int v;
      v = 0;
      for (int b = 0; b < 5; b++) if (((s >> b) & 1) == 1) v += item_val[b];
      v = v % 32;
      if (m[s]) begin
        cnt++;
        if (fnd == 0 || v > val) begin
          fnd = 1; sel = s; val = v;
        end
      end
    end
  endtask

  // Pulse start, follow the scan, and compare the results to the expectations.
  task automatic run_scan(input logic [31:0] m, input string tag, input int e_cnt,
                          input int e_fnd, input int e_sel, input int e_val);
    int cyc;
    int ncand;
    int bad;
    logic got;
    mask_v = m;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 1; ncand = 0; bad = 0; got = 1'b0;
    while (cyc < 100) begin
      if (done) begin got = 1'b1; break; end
      if (busy) begin
        if (int'(candidate) != ncand) bad++;
        ncand++;
      end
      @(negedge clk); cyc++;
    end
    check({tag, "_done_seen"}, int'(got), 1);
    check({tag, "_latency"}, cyc, 33);
    check({tag, "_cand_seq"}, (ncand == 32 && bad == 0) ? 1 : 0, 1);
    check({tag, "_count"}, int'(valid_count), e_cnt);
    check({tag, "_found"}, int'(best_found), e_fnd);
    check({tag, "_sel"}, int'(best_sel), e_sel);
    check({tag, "_value"}, int'(best_value), e_val);
    @(negedge clk);
    check({tag, "_done_pulse"}, int'(done), 0);
    check({tag, "_idle"}, int'(busy), 0);
    check({tag, "_hold_count"}, int'(valid_count), e_cnt);
  endtask

  initial begin
    int   c, f, s, v;
    int   ncand, bad, cyc;
    logic saw_done;

    pass_cnt = 0; total_cnt = 0;
    rst = 1'b1; start = 1'b0; mask_v = 32'h0;

    vecs[0] = '{32'h4000_0000, 1, 1, 30, 15, "only11110"};
    vecs[1] = '{32'hFFFF_FFFF, 32, 1, 31, 19, "all_valid"};
    vecs[2] = '{32'h0000_0000, 0, 0, 0, 0, "none_valid"};
    vecs[3] = '{32'h0000_0048, 2, 1, 3, 6, "pick_best"};
    vecs[4] = '{32'h0000_0014, 2, 1, 2, 2, "tie_first"};

    repeat (2) @(negedge clk);
    check("rst_candidate", int'(candidate), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_found", int'(best_found), 0);
    check("rst_sel", int'(best_sel), 0);
    check("rst_value", int'(best_value), 0);
    check("rst_count", int'(valid_count), 0);
    rst = 1'b0;

    // Directed table.
    for (int i = 0; i < 5; i++)
      run_scan(vecs[i].mask, vecs[i].tag, vecs[i].count, vecs[i].found,
               vecs[i].sel, vecs[i].value);

    // Randomized masks against the reference model.
    for (int i = 0; i < 8; i++) begin
      logic [31:0] m;
      m = $urandom;
      if (i == 0) m = m & $urandom & $urandom;
      model(m, c, f, s, v);
      run_scan(m, $sformatf("rand%0d", i), c, f, s, v);
    end

    // Reset during SCAN cycle 10 aborts with cleared results and no done.
    mask_v = 32'hFFFF_FFFF;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (candidate != 5'd9 && cyc < 50) begin @(negedge clk); cyc++; end
    check("mid_count_before_rst", int'(valid_count), 9);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_candidate", int'(candidate), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_count", int'(valid_count), 0);
    check("mid_rst_found", int'(best_found), 0);
    check("mid_rst_sel", int'(best_sel), 0);
    check("mid_rst_value", int'(best_value), 0);
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    check("mid_rst_no_done", int'(saw_done), 0);
    run_scan(32'hFFFF_FFFF, "after_rst", 32, 1, 31, 19);

    // start held high (with a re-pulse mid-scan): one clean scan, re-accept only from IDLE.
    mask_v = 32'h0000_0048;
    @(negedge clk); start = 1'b1;
    @(negedge clk);
    cyc = 1; ncand = 0; bad = 0; saw_done = 1'b0;
    while (cyc < 100) begin
      if (done) begin saw_done = 1'b1; break; end
      if (busy) begin
        if (int'(candidate) != ncand) bad++;
        ncand++;
      end
      start = (cyc == 12) ? 1'b0 : 1'b1;
      @(negedge clk); cyc++;
    end
    check("held_done_seen", int'(saw_done), 1);
    check("held_latency", cyc, 33);
    check("held_cand_seq", (ncand == 32 && bad == 0) ? 1 : 0, 1);
    check("held_sel", int'(best_sel), 3);
    @(negedge clk);
    check("held_idle_gap", int'(busy), 0);
    @(negedge clk);
    start = 1'b0;
    check("held_restart_busy", int'(busy), 1);
    check("held_restart_cand", int'(candidate), 0);
    check("held_restart_cleared", int'(valid_count), 0);
    cyc = 0;
    while (!done && cyc < 100) begin @(negedge clk); cyc++; end
    check("held_second_done", int'(done), 1);
    @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
